lq_agen_csel_pipe: RTL and testbench
====================================

// Module: lq_agen_csel_pipe
// PURPOSE
//  Parametrised two-stage pipelined carry-select address adder for the LQ AGEN path.
//  ex1 operands are registered; ex2 forms per-group conditional sums (carry-in 0 and carry-in 1) and group generate/transmit.
//  ex2 exports those conditional sums early for ERAT/directory lookup.
//  ex3 resolves inter-group carries and delivers the selected EA, with 32/64-bit mode masking, hold and flush.
// PARAMETERS
//  WIDTH  64  adder width; bit 0 = MSB; WIDTH must be a multiple of GROUP
//  GROUP  8   bits per carry-select group; NG = WIDTH/GROUP
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active high
//  ex1_vld        in   1        operands valid
//  ex1_x          in   WIDTH    operand A [0:WIDTH-1]
//  ex1_y          in   WIDTH    operand B
//  ex1_cin        in   1        carry into bit WIDTH-1
//  ex1_mode64     in   1        1 = 64-bit EA; 0 = 32-bit EA (upper WIDTH-32 bits zeroed)
//  hold           in   1        stall: all pipeline registers keep their value
//  flush          in   1        kill: ex2/ex3 valids clear; data is don't-care
//  ex2_vld        out  1        ex2 stage valid
//  ex2_sum_0      out  WIDTH    per-group sum assuming group carry-in 0
//  ex2_sum_1      out  WIDTH    per-group sum assuming group carry-in 1
//  ex2_grp_g      out  NG       group generate
//  ex2_grp_t      out  NG       group transmit (g|p chain)
//  ex3_vld        out  1        result valid
//  ex3_sum        out  WIDTH    final EA (mode-masked)
//  ex3_cout       out  1        carry out of bit 0 (mode64=1) or bit WIDTH-32 (mode64=0)
// BEHAVIOUR
//  - Reset: ex2_vld = ex3_vld = 0. All ex2/ex3 data registers = 0, so every output reads 0.
//  - Latency: ex1 operands -> ex2 outputs after 1 clk -> ex3 outputs after 2 clk. No bubbles; throughput 1 op/clk.
//  - ex2: registers x, y, cin and mode64.
//    - Per group k: sum_0 = x+y with carry-in 0, sum_1 = x+y with carry-in 1, each truncated to GROUP bits.
//    - g = the group carries out with carry-in 0; t = the group carries out with carry-in 1.
//  - ex3 carry chain, from group NG-1 (LSB group) upward:
//    - c[NG-1] = cin; c[k-1] = g[k] | (t[k] & c[k]).
//    - Result bits of group k = c[k] ? sum_1 : sum_0.
//  - The ex3 register stores the selected sum and cout; the chain is combinational inside ex2->ex3.
//  - mode64=0: ex3_sum[0:WIDTH-33] = 0 and ex3_cout = carry into bit WIDTH-33.
//  - mode64 only masks; the adder always computes full width.
//  - Valid update with no hold: ex2_vld <= ex1_vld & ~flush; ex3_vld <= ex2_vld & ~flush.
//  - hold=1: every register, valid and data, keeps its value; ex1 inputs are ignored (the producer must also hold).
//  - flush & hold together: flush wins for valids (both clear); data registers hold.
//  - rst overrides hold and flush.
//  - Group-carry wrap: the all-ones + cin=1 case must propagate through every group in one cycle (timing: NG <= 8).
//  - Data registers load whenever hold=0, independent of valid; a one-hot vld gate is permitted for power.
// STRUCTURE
//  - Package lq_agen_pkg:
//    - localparam NG helper function;
//    - typedef for group g/t vectors;
//    - the mode-mask constant EA32_MASK.
//  - Sub-module lq_agen_csel_grp #(GROUP):
//    - one group's conditional sums and g/t;
//    - generalises the existing 8-bit local carry-select slice to GROUP bits;
//    - instantiated NG times via generate.
//  - Top module holds:
//    - ex2/ex3 registers;
//    - the carry chain;
//    - mode masking;
//    - valid/hold/flush control.
// TESTING (WIDTH=64, GROUP=8)
//  1. x=0x0000_0000_0000_00FF, y=0x1, cin=0, mode64=1 -> ex3_sum=0x0000_0000_0000_0100, cout=0, 2 clk after issue.
//  2. x=0xFFFF_FFFF_FFFF_FFFF, y=0, cin=1 -> ex3_sum=0, cout=1.
//     - Also check the ex2 early outputs: ex2_sum_0 group7=0xFF, ex2_sum_1 group7=0x00, all t=1, all g=0.
//  3. x=0x0000_0001_FFFF_FFFF, y=0x1, cin=0, mode64=0 -> ex3_sum=0x0000_0000_0000_0000, cout=1.
//     - Same operands with mode64=1 -> ex3_sum=0x0000_0002_0000_0000, cout=0.
//  4. Back-to-back ops A,B,C; assert hold for 3 clk while A is in ex3 and B in ex2 -> outputs frozen.
//     - After release, A, B, C emerge in order with no duplication.
//  5. flush with op in ex2 and ex3, also with hold=1 -> both valids 0 next clk.
//     - A new op issued the following clk appears normally.
//  6. rst asserted mid-stream with hold=1 -> next clk ex2_vld=ex3_vld=0, ex3_sum=0.
//     - Follow with 10k random ops at random hold/flush vs a behavioural model (x+y+cin, masked).

Source files
------------

// File: rtl/lq_agen_pkg.sv
// Shared constants, types and helpers for the LQ AGEN carry-select adder.
package lq_agen_pkg;

  localparam int NG_MAX = 8;
  localparam logic [63:0] EA32_MASK = 64'h0000_0000_FFFF_FFFF;

  typedef logic [0:NG_MAX-1] grp_vec_t;

  function automatic int ng_of(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/lq_agen_csel_grp.sv
// One carry-select group: conditional sums for carry-in 0/1 plus group generate/transmit.
module lq_agen_csel_grp #(
  parameter int GROUP = 8
) (
  input  logic [0:GROUP-1] x,
  input  logic [0:GROUP-1] y,
  output logic [0:GROUP-1] sum_0,
  output logic [0:GROUP-1] sum_1,
  output logic             g,
  output logic             t
);

  logic [GROUP:0] add_0;
  logic [GROUP:0] add_1;

  assign add_0 = {1'b0, x} + {1'b0, y};
  assign add_1 = {1'b0, x} + {1'b0, y} + {{GROUP{1'b0}}, 1'b1};

  assign sum_0 = add_0[GROUP-1:0];
  assign sum_1 = add_1[GROUP-1:0];
  assign g     = add_0[GROUP];
  assign t     = add_1[GROUP];

endmodule

// File: rtl/lq_agen_csel_pipe.sv
// Two-stage carry-select EA adder: group sums registered into ex2, carry chain
// and mode masking resolved into the ex3 result register.
module lq_agen_csel_pipe
  import lq_agen_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int GROUP = 8,
  localparam int NG    = ng_of(WIDTH, GROUP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex1_vld,
  input  logic [0:WIDTH-1] ex1_x,
  input  logic [0:WIDTH-1] ex1_y,
  input  logic             ex1_cin,
  input  logic             ex1_mode64,
  input  logic             hold,
  input  logic             flush,
  output logic             ex2_vld,
  output logic [0:WIDTH-1] ex2_sum_0,
  output logic [0:WIDTH-1] ex2_sum_1,
  output logic [0:NG-1]    ex2_grp_g,
  output logic [0:NG-1]    ex2_grp_t,
  output logic             ex3_vld,
  output logic [0:WIDTH-1] ex3_sum,
  output logic             ex3_cout
);

  // Group whose carry-out is the carry into the upper (WIDTH-32) bits.
  localparam int LO_GRP = NG - (32 / GROUP);
  localparam logic [0:WIDTH-1] MASK32 = EA32_MASK[WIDTH-1:0];

  logic [0:WIDTH-1] grp_sum_0;
  logic [0:WIDTH-1] grp_sum_1;
  logic [0:NG-1]    grp_g;
  logic [0:NG-1]    grp_t;

  logic             ex2_cin;
  logic             ex2_mode64;

  logic [0:WIDTH-1] sel_sum;
  logic             chain_c;
  logic             cout32;
  logic [0:WIDTH-1] ea_mask;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    lq_agen_csel_grp #(.GROUP(GROUP)) u_grp (
      .x     (ex1_x[k*GROUP +: GROUP]),
      .y     (ex1_y[k*GROUP +: GROUP]),
      .sum_0 (grp_sum_0[k*GROUP +: GROUP]),
      .sum_1 (grp_sum_1[k*GROUP +: GROUP]),
      .g     (grp_g[k]),
      .t     (grp_t[k])
    );
  end

  // Ripple the group carries from the LSB group upward and pick each group's sum.
  always_comb begin
    chain_c = ex2_cin;
    cout32  = 1'b0;
    sel_sum = '0;
    for (int k = NG - 1; k >= 0; k--) begin
      sel_sum[k*GROUP +: GROUP] = chain_c ? ex2_sum_1[k*GROUP +: GROUP]
                                          : ex2_sum_0[k*GROUP +: GROUP];
      chain_c = ex2_grp_g[k] | (ex2_grp_t[k] & chain_c);
      cout32  = (k == LO_GRP) ? chain_c : cout32;
    end
    ea_mask = ex2_mode64 ? {WIDTH{1'b1}} : MASK32;
  end

  // Pipeline registers; flush clears valids even while held, data only moves when not held.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex2_vld    <= 1'b0;
      ex2_sum_0  <= '0;
      ex2_sum_1  <= '0;
      ex2_grp_g  <= '0;
      ex2_grp_t  <= '0;
      ex2_cin    <= 1'b0;
      ex2_mode64 <= 1'b0;
      ex3_vld    <= 1'b0;
      ex3_sum    <= '0;
      ex3_cout   <= 1'b0;
    end else if (!hold) begin
      ex2_vld    <= ex1_vld & ~flush;
      ex2_sum_0  <= grp_sum_0;
      ex2_sum_1  <= grp_sum_1;
      ex2_grp_g  <= grp_g;
      ex2_grp_t  <= grp_t;
      ex2_cin    <= ex1_cin;
      ex2_mode64 <= ex1_mode64;
      ex3_vld    <= ex2_vld & ~flush;
      ex3_sum    <= sel_sum & ea_mask;
      ex3_cout   <= ex2_mode64 ? chain_c : cout32;
    end else if (flush) begin
      ex2_vld <= 1'b0;
      ex3_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lq_agen_csel_pipe.sv
// Directed and model-based checks of the LQ AGEN carry-select pipeline (WIDTH=64, GROUP=8).
module tb_lq_agen_csel_pipe;
  import lq_agen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex1_vld = 1'b0;
  logic [63:0] ex1_x = 64'h0;
  logic [63:0] ex1_y = 64'h0;
  logic        ex1_cin = 1'b0;
  logic        ex1_mode64 = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        ex2_vld;
  logic [63:0] ex2_sum_0;
  logic [63:0] ex2_sum_1;
  grp_vec_t    ex2_grp_g;
  grp_vec_t    ex2_grp_t;
  logic        ex3_vld;
  logic [63:0] ex3_sum;
  logic        ex3_cout;

  int n_checks = 0;
  int n_errors = 0;

  lq_agen_csel_pipe #(.WIDTH(64), .GROUP(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex1_vld    (ex1_vld),
    .ex1_x      (ex1_x),
    .ex1_y      (ex1_y),
    .ex1_cin    (ex1_cin),
    .ex1_mode64 (ex1_mode64),
    .hold       (hold),
    .flush      (flush),
    .ex2_vld    (ex2_vld),
    .ex2_sum_0  (ex2_sum_0),
    .ex2_sum_1  (ex2_sum_1),
    .ex2_grp_g  (ex2_grp_g),
    .ex2_grp_t  (ex2_grp_t),
    .ex3_vld    (ex3_vld),
    .ex3_sum    (ex3_sum),
    .ex3_cout   (ex3_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] x, input logic [63:0] y,
                       input logic c, input logic m);
    ex1_vld = v; ex1_x = x; ex1_y = y; ex1_cin = c; ex1_mode64 = m;
  endtask

  // Behavioural EA: {cout, masked sum}
  function automatic logic [64:0] ref_ea(input logic [63:0] x, input logic [63:0] y,
                                         input logic c, input logic m);
    logic [64:0] full;
    logic [32:0] lo;
    full = {1'b0, x} + {1'b0, y} + {64'h0, c};
    lo   = {1'b0, x[31:0]} + {1'b0, y[31:0]} + {32'h0, c};
    if (m) return full;
    else   return {lo[32], 32'h0, lo[31:0]};
  endfunction

  logic        m2_vld, m3_vld, m2_cin, m2_mode, r_hold, r_flush, r_vld, r_cin, r_mode;
  logic [63:0] m2_x, m2_y, r_x, r_y;
  logic [64:0] m3_res;

  initial begin
    // Reset state
    rst = 1'b1; tick; rst = 1'b0;
    check("rst_ex2_vld", {63'h0, ex2_vld}, 64'h0);
    check("rst_ex3_vld", {63'h0, ex3_vld}, 64'h0);
    check("rst_ex3_sum", ex3_sum, 64'h0);
    check("rst_ex3_cout", {63'h0, ex3_cout}, 64'h0);
    check("rst_ex2_sum_0", ex2_sum_0, 64'h0);
    check("rst_ex2_sum_1", ex2_sum_1, 64'h0);
    check("rst_ex2_gt", {48'h0, ex2_grp_g, ex2_grp_t}, 64'h0);

    // 1: carry across a group boundary
    drive(1'b1, 64'h0000_0000_0000_00FF, 64'h1, 1'b0, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t1_ex2_vld", {63'h0, ex2_vld}, 64'h1);
    check("t1_ex3_vld_early", {63'h0, ex3_vld}, 64'h0);
    check("t1_ex2_sum_0", ex2_sum_0, 64'h0);
    check("t1_ex2_sum_1", ex2_sum_1, 64'h0101_0101_0101_0101);
    check("t1_ex2_g", {56'h0, ex2_grp_g}, 64'h01);
    check("t1_ex2_t", {56'h0, ex2_grp_t}, 64'h01);
    tick;
    check("t1_ex3_vld", {63'h0, ex3_vld}, 64'h1);
    check("t1_ex3_sum", ex3_sum, 64'h0000_0000_0000_0100);
    check("t1_ex3_cout", {63'h0, ex3_cout}, 64'h0);

    // 2: full-width wrap with cin
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t2_ex2_sum_0_g7", {56'h0, ex2_sum_0[7:0]}, 64'hFF);
    check("t2_ex2_sum_1_g7", {56'h0, ex2_sum_1[7:0]}, 64'h00);
    check("t2_ex2_t", {56'h0, ex2_grp_t}, 64'hFF);
    check("t2_ex2_g", {56'h0, ex2_grp_g}, 64'h00);
    tick;
    check("t2_ex3_sum", ex3_sum, 64'h0);
    check("t2_ex3_cout", {63'h0, ex3_cout}, 64'h1);

    // 3: 32-bit mode masking, then same operands in 64-bit mode
    drive(1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 1'b0); tick;
    drive(1'b1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t3_m32_sum", ex3_sum, 64'h0);
    check("t3_m32_cout", {63'h0, ex3_cout}, 64'h1);
    tick;
    check("t3_m64_sum", ex3_sum, 64'h0000_0002_0000_0000);
    check("t3_m64_cout", {63'h0, ex3_cout}, 64'h0);

    // 4: hold with A in ex3, B in ex2, C waiting at ex1
    drive(1'b1, 64'h10, 64'h20, 1'b0, 1'b1); tick;
    drive(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b1); tick;
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t4_hold_ex3_vld", {63'h0, ex3_vld}, 64'h1);
      check("t4_hold_ex3_sum", ex3_sum, 64'h30);
      check("t4_hold_ex2_vld", {63'h0, ex2_vld}, 64'h1);
      check("t4_hold_ex2_sum_0", ex2_sum_0, 64'h3333_3333_3333_3333);
    end
    hold = 1'b0; tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t4_b_sum", ex3_sum, 64'h3333_3333_3333_3333);
    check("t4_b_vld", {63'h0, ex3_vld}, 64'h1);
    tick;
    check("t4_c_sum", ex3_sum, 64'h1);
    check("t4_c_cout", {63'h0, ex3_cout}, 64'h1);
    check("t4_c_vld", {63'h0, ex3_vld}, 64'h1);
    tick;
    check("t4_no_dup", {63'h0, ex3_vld}, 64'h0);

    // 5: flush, then flush with hold, each followed by a fresh op
    drive(1'b1, 64'h5, 64'h6, 1'b0, 1'b1); tick;
    drive(1'b1, 64'h7, 64'h8, 1'b0, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1); flush = 1'b1; tick; flush = 1'b0;
    check("t5_flush_ex2_vld", {63'h0, ex2_vld}, 64'h0);
    check("t5_flush_ex3_vld", {63'h0, ex3_vld}, 64'h0);
    drive(1'b1, 64'h100, 64'h23, 1'b1, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1); tick;
    check("t5_new_vld", {63'h0, ex3_vld}, 64'h1);
    check("t5_new_sum", ex3_sum, 64'h124);
    drive(1'b1, 64'h40, 64'h2, 1'b0, 1'b1); tick;
    drive(1'b1, 64'h7, 64'h8, 1'b0, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1); hold = 1'b1; flush = 1'b1; tick;
    hold = 1'b0; flush = 1'b0;
    check("t5_hflush_ex2_vld", {63'h0, ex2_vld}, 64'h0);
    check("t5_hflush_ex3_vld", {63'h0, ex3_vld}, 64'h0);
    check("t5_hflush_ex3_data", ex3_sum, 64'h42);
    drive(1'b1, 64'h9, 64'h9, 1'b0, 1'b1); tick;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t5_new2_ex2_vld", {63'h0, ex2_vld}, 64'h1);
    tick;
    check("t5_new2_vld", {63'h0, ex3_vld}, 64'h1);
    check("t5_new2_sum", ex3_sum, 64'h12);

    // 6: reset beats hold mid-stream
    drive(1'b1, 64'h1234, 64'h1, 1'b0, 1'b1); tick;
    drive(1'b1, 64'h5678, 64'h1, 1'b0, 1'b1); tick;
    hold = 1'b1; rst = 1'b1; tick;
    hold = 1'b0; rst = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t6_rst_ex2_vld", {63'h0, ex2_vld}, 64'h0);
    check("t6_rst_ex3_vld", {63'h0, ex3_vld}, 64'h0);
    check("t6_rst_ex3_sum", ex3_sum, 64'h0);

    // Random ops against the behavioural model
    m2_vld = 1'b0; m3_vld = 1'b0; m2_cin = 1'b0; m2_mode = 1'b0;
    m2_x = 64'h0; m2_y = 64'h0; m3_res = 65'h0;
    for (int i = 0; i < 10000; i++) begin
      r_x     = {$urandom, $urandom};
      r_y     = {$urandom, $urandom};
      r_cin   = 1'($urandom_range(1, 0));
      r_mode  = 1'($urandom_range(1, 0));
      r_vld   = ($urandom_range(3, 0) != 0);
      r_hold  = ($urandom_range(7, 0) == 0);
      r_flush = ($urandom_range(7, 0) == 0);
      if (i % 16 == 0) begin
        r_x = 64'hFFFF_FFFF_FFFF_FFFF; r_y = 64'h0; r_cin = 1'b1;
      end
      drive(r_vld, r_x, r_y, r_cin, r_mode);
      hold = r_hold; flush = r_flush;
      if (!r_hold) begin
        m3_res = ref_ea(m2_x, m2_y, m2_cin, m2_mode);
        m3_vld = m2_vld & ~r_flush;
        m2_x = r_x; m2_y = r_y; m2_cin = r_cin; m2_mode = r_mode;
        m2_vld = r_vld & ~r_flush;
      end else if (r_flush) begin
        m2_vld = 1'b0;
        m3_vld = 1'b0;
      end
      tick;
      check("rnd_ex2_vld", {63'h0, ex2_vld}, {63'h0, m2_vld});
      check("rnd_ex3_vld", {63'h0, ex3_vld}, {63'h0, m3_vld});
      if (m3_vld) begin
        check("rnd_ex3_sum", ex3_sum, m3_res[63:0]);
        check("rnd_ex3_cout", {63'h0, ex3_cout}, {63'h0, m3_res[64]});
      end
    end
    hold = 1'b0; flush = 1'b0; ex1_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
